sdram_stream_scheduler: RTL



---
 rtl/sdram_sched_pkg.sv | 31 +++
 rtl/sdram_refresh_timer.sv | 59 +++++
 rtl/sdram_stream_scheduler.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_sched_pkg.sv
// Shared types and constants for the SDRAM stream scheduler:
// command opcodes, scheduler state encoding, the 48 MHz refresh interval
// and a saturating increment used by the optional burst statistics.
package sdram_sched_pkg;

    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_WRITE   = 2'd1,
        OP_READ    = 2'd2,
        OP_REFRESH = 2'd3
    } sched_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } sched_state_e;

    // 7.8 us refresh interval at 48 MHz
    localparam int REFRESH_TICKS_48M = 374;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            return value;
        end else begin
            return value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval timer. Raises refresh_pending_o at each
// terminal count until the scheduler reports the refresh done; flags a
// sticky miss when a new interval expires with the previous refresh
// still outstanding.
module sdram_refresh_timer
    import sdram_sched_pkg::*;
#(
    parameter int REFRESH_TICKS = REFRESH_TICKS_48M
) (
    input  logic clk,
    input  logic n_rst,
    input  logic refresh_done_i,
    output logic refresh_pending_o,
    output logic refresh_miss_o
);

    localparam int CNT_W = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_TICKS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             miss_q, miss_d;
    logic             terminal_s;

    // Next-state for counter, pending flag and sticky miss flag
    always_comb begin
        terminal_s = (cnt_q == CNT_LAST);
        if (terminal_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (terminal_s) begin
            pending_d = 1'b1;
        end else if (refresh_done_i) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        miss_d = miss_q | (terminal_s & pending_q);
    end

    // Timer state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            miss_q    <= miss_d;
        end
    end

    assign refresh_pending_o = pending_q;
    assign refresh_miss_o    = miss_q;

endmodule

// File: rtl/sdram_stream_scheduler.sv
// SDRAM ring-buffer scheduler for the stream-test datapath. Issues one
// write burst, read burst or auto-refresh at a time to the SDRAM
// controller (refresh first, write/read round-robin) and owns the ring
// pointers, fill level and status flags.
// Optional feature: define SDRAM_SCHED_STATS_EN for saturating burst
// counters on wr_bursts/rd_bursts; otherwise both ports read as zero.
module sdram_stream_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int ADDR_W        = 24,
    parameter int BURST_LEN     = 256,
    parameter int USEDW_W       = 10,
    parameter int FIFO_DEPTH    = 1024,
    parameter int REFRESH_TICKS = REFRESH_TICKS_48M
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               enable,
    input  logic               clear,
    input  logic [USEDW_W-1:0] wr_fifo_usedw,
    input  logic [USEDW_W-1:0] rd_fifo_usedw,
    output logic               cmd_valid,
    output logic [1:0]         cmd_op,
    output logic [ADDR_W-1:0]  cmd_addr,
    input  logic               cmd_ack,
    input  logic               cmd_done,
    output logic [ADDR_W:0]    level,
    output logic               ring_empty,
    output logic               ring_full,
    output logic               in_overflow,
    output logic               refresh_miss,
    output logic [31:0]        wr_bursts,
    output logic [31:0]        rd_bursts
);

    localparam logic [ADDR_W:0]   RING_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   BURST_LVL  = (ADDR_W+1)'(BURST_LEN);
    localparam logic [ADDR_W:0]   WR_MAX_LVL = RING_WORDS - BURST_LVL;
    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
    localparam logic [31:0]       WR_MIN_USED = 32'(BURST_LEN);
    localparam logic [31:0]       RD_MAX_USED = 32'(FIFO_DEPTH - BURST_LEN);
    localparam logic [31:0]       OVF_USED    = 32'(FIFO_DEPTH - 1);

    sched_state_e      state_q, state_d;
    sched_op_e         op_q, op_d;
    sched_op_e         cmd_op_q, cmd_op_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              ovf_q, ovf_d;
    logic              clear_pend_q, clear_pend_d;
    logic              last_wr_q, last_wr_d;   // 1: last write/read grant was WRITE

    logic [31:0] wr_used_s, rd_used_s;
    logic        wr_elig_s, rd_elig_s;
    logic        refresh_pending_s, refresh_done_s;

    assign wr_used_s      = 32'(wr_fifo_usedw);
    assign rd_used_s      = 32'(rd_fifo_usedw);
    assign wr_elig_s      = enable && (wr_used_s >= WR_MIN_USED) && (level_q <= WR_MAX_LVL);
    assign rd_elig_s      = (level_q >= BURST_LVL) && (rd_used_s <= RD_MAX_USED);
    assign refresh_done_s = (state_q == ST_BUSY) && cmd_done && (op_q == OP_REFRESH);

    sdram_refresh_timer #(
        .REFRESH_TICKS (REFRESH_TICKS)
    ) u_refresh_timer (
        .clk               (clk),
        .n_rst             (n_rst),
        .refresh_done_i    (refresh_done_s),
        .refresh_pending_o (refresh_pending_s),
        .refresh_miss_o    (refresh_miss)
    );

    // Arbitration, command handshake and ring bookkeeping
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_op_d     = cmd_op_q;
        cmd_addr_d   = cmd_addr_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        clear_pend_d = clear_pend_q;
        last_wr_d    = last_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    // Skip arbitration this cycle so no grant uses pre-clear state
                    wr_ptr_d     = '0;
                    rd_ptr_d     = '0;
                    level_d      = '0;
                    clear_pend_d = 1'b0;
                    cmd_valid_d  = 1'b0;
                    cmd_op_d     = OP_NOP;
                end else if (refresh_pending_s) begin
                    state_d     = ST_ISSUE;
                    op_d        = OP_REFRESH;
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = OP_REFRESH;
                    cmd_addr_d  = '0;
                end else if (wr_elig_s && (!rd_elig_s || !last_wr_q)) begin
                    state_d     = ST_ISSUE;
                    op_d        = OP_WRITE;
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = OP_WRITE;
                    cmd_addr_d  = wr_ptr_q;
                    last_wr_d   = 1'b1;
                end else if (rd_elig_s) begin
                    state_d     = ST_ISSUE;
                    op_d        = OP_READ;
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = OP_READ;
                    cmd_addr_d  = rd_ptr_q;
                    last_wr_d   = 1'b0;
                end else begin
                    cmd_valid_d = 1'b0;
                    cmd_op_d    = OP_NOP;
                end
            end
            ST_ISSUE: begin
                if (clear) begin
                    clear_pend_d = 1'b1;
                end else begin
                    clear_pend_d = clear_pend_q;
                end
                if (cmd_ack) begin
                    state_d     = ST_BUSY;
                    cmd_valid_d = 1'b0;
                    cmd_op_d    = OP_NOP;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_BUSY: begin
                if (cmd_done) begin
                    state_d = ST_IDLE;
                    if (clear || clear_pend_q) begin
                        wr_ptr_d     = '0;
                        rd_ptr_d     = '0;
                        level_d      = '0;
                        clear_pend_d = 1'b0;
                    end else begin
                        case (op_q)
                            OP_WRITE: begin
                                wr_ptr_d = wr_ptr_q + BURST_STEP;
                                level_d  = level_q + BURST_LVL;
                            end
                            OP_READ: begin
                                rd_ptr_d = rd_ptr_q + BURST_STEP;
                                level_d  = level_q - BURST_LVL;
                            end
                            default: begin
                                level_d = level_q;
                            end
                        endcase
                    end
                end else if (clear) begin
                    clear_pend_d = 1'b1;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_valid_d = 1'b0;
                cmd_op_d    = OP_NOP;
            end
        endcase
        empty_d = (level_d == '0);
        full_d  = (level_d == RING_WORDS);
        ovf_d   = ovf_q | (wr_used_s >= OVF_USED);
    end

    // Scheduler registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_NOP;
            cmd_valid_q  <= 1'b0;
            cmd_op_q     <= OP_NOP;
            cmd_addr_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            ovf_q        <= 1'b0;
            clear_pend_q <= 1'b0;
            last_wr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_op_q     <= cmd_op_d;
            cmd_addr_q   <= cmd_addr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            ovf_q        <= ovf_d;
            clear_pend_q <= clear_pend_d;
            last_wr_q    <= last_wr_d;
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_op      = cmd_op_q;
    assign cmd_addr    = cmd_addr_q;
    assign level       = level_q;
    assign ring_empty  = empty_q;
    assign ring_full   = full_q;
    assign in_overflow = ovf_q;

`ifdef SDRAM_SCHED_STATS_EN
    logic [31:0] wr_bursts_q, wr_bursts_d;
    logic [31:0] rd_bursts_q, rd_bursts_d;
    logic        wr_done_s, rd_done_s;

    assign wr_done_s = (state_q == ST_BUSY) && cmd_done && (op_q == OP_WRITE);
    assign rd_done_s = (state_q == ST_BUSY) && cmd_done && (op_q == OP_READ);

    // Saturating completed-burst counters, zeroed by clear
    always_comb begin
        wr_bursts_d = wr_bursts_q;
        rd_bursts_d = rd_bursts_q;
        if (clear) begin
            wr_bursts_d = 32'd0;
            rd_bursts_d = 32'd0;
        end else begin
            if (wr_done_s) begin
                wr_bursts_d = sat_inc32(wr_bursts_q);
            end else begin
                wr_bursts_d = wr_bursts_q;
            end
            if (rd_done_s) begin
                rd_bursts_d = sat_inc32(rd_bursts_q);
            end else begin
                rd_bursts_d = rd_bursts_q;
            end
        end
    end

    // Statistics registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_bursts_q <= 32'd0;
            rd_bursts_q <= 32'd0;
        end else begin
            wr_bursts_q <= wr_bursts_d;
            rd_bursts_q <= rd_bursts_d;
        end
    end

    assign wr_bursts = wr_bursts_q;
    assign rd_bursts = rd_bursts_q;
`else
    assign wr_bursts = 32'd0;
    assign rd_bursts = 32'd0;
`endif

endmodule
